// File: rtl/qam_demap_pkg.sv
`default_nettype none
// ============================================================================
// Module      : qam_demap_pkg
// Description : Shared mode encodings, FSM state type and helper functions
//               for the serial QAM demapper.
// Revision    : 1.0 - initial release
// ============================================================================
package qam_demap_pkg;

    localparam logic [1:0] MODE_QPSK = 2'b00;
    localparam logic [1:0] MODE_16   = 2'b01;
    localparam logic [1:0] MODE_64   = 2'b10;
    localparam logic [1:0] MODE_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CAL   = 2'd1,
        ST_DEMAP = 2'd2,
        ST_SHIFT = 2'd3
    } state_t;

    // Reserved mode falls back to QPSK framing.
    function automatic logic [2:0] bps_of(input logic [1:0] m);
        case (m)
            MODE_16: bps_of = 3'd4;
            MODE_64: bps_of = 3'd6;
            default: bps_of = 3'd2;
        endcase
    endfunction

    function automatic logic [2:0] gray3(input logic [2:0] k);
        gray3 = k ^ {1'b0, k[2:1]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/qam_axis_slicer.sv
`default_nettype none
// ============================================================================
// Module      : qam_axis_slicer
// Description : Per-axis offset removal, saturation, decision slicing and
//               Gray encoding. Purely combinational.
// Revision    : 1.0 - initial release
// ============================================================================
module qam_axis_slicer
    import qam_demap_pkg::*;
#(
    parameter int IN_W      = 8,
    parameter int STEP_LOG2 = 4
) (
    input  logic [IN_W-1:0] sample,
    input  logic [IN_W-1:0] offset,
    input  logic [1:0]      mode,
    output logic [2:0]      gray,
    output logic [1:0]      width
);

    logic signed [IN_W:0]   w_diff;
    logic signed [IN_W-1:0] w_sat;
    logic signed [IN_W-1:0] w_sh16;
    logic signed [IN_W-1:0] w_sh64;
    logic signed [IN_W-1:0] w_k16;
    logic signed [IN_W-1:0] w_k64;
    logic [2:0]             w_c16;
    logic [2:0]             w_c64;
    logic [2:0]             w_k;

    assign w_diff = $signed({sample[IN_W-1], sample}) - $signed({offset[IN_W-1], offset});

    // Differing top two bits of the widened difference mean it left the IN_W range.
    always_comb begin
        if (w_diff[IN_W] != w_diff[IN_W-1]) begin
            w_sat = w_diff[IN_W] ? {1'b1, {(IN_W-1){1'b0}}} : {1'b0, {(IN_W-1){1'b1}}};
        end else begin
            w_sat = w_diff[IN_W-1:0];
        end
    end

    assign w_sh16 = w_sat >>> (STEP_LOG2 + 1);
    assign w_sh64 = w_sat >>> STEP_LOG2;
    assign w_k16  = w_sh16 + $signed(IN_W'(2));
    assign w_k64  = w_sh64 + $signed(IN_W'(4));

    assign w_c16 = w_k16[IN_W-1]        ? 3'd0 :
                   (|w_k16[IN_W-2:2])   ? 3'd3 : {1'b0, w_k16[1:0]};
    assign w_c64 = w_k64[IN_W-1]        ? 3'd0 :
                   (|w_k64[IN_W-2:3])   ? 3'd7 : w_k64[2:0];

    always_comb begin
        w_k   = {2'b00, ~w_sat[IN_W-1]};
        width = 2'd1;
        case (mode)
            MODE_16: begin
                w_k   = w_c16;
                width = 2'd2;
            end
            MODE_64: begin
                w_k   = w_c64;
                width = 2'd3;
            end
            default: begin
                w_k   = {2'b00, ~w_sat[IN_W-1]};
                width = 2'd1;
            end
        endcase
    end

    assign gray = gray3(w_k);

endmodule
`default_nettype wire

// File: rtl/qam_demapper_serial.sv
`default_nettype none
// ============================================================================
// Module      : qam_demapper_serial
// Description : Multi-mode hard-decision QAM demapper with DC-offset
//               calibration and MSB-first serial output. Defining
//               QAM_DEMAP_PARITY_EN appends an even-parity bit to each frame.
// Revision    : 1.0 - initial release
// ============================================================================
module qam_demapper_serial
    import qam_demap_pkg::*;
#(
    parameter int IN_W      = 8,
    parameter int STEP_LOG2 = 4,
    parameter int CAL_LOG2  = 2
) (
    input  logic            dclk,
    input  logic            rst,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [IN_W-1:0] i_in,
    input  logic [IN_W-1:0] q_in,
    input  logic [1:0]      mode,
    input  logic            cal_req,
    output logic            cal_done,
    output logic            data_out,
    output logic            data_valid,
    output logic            sym_start,
    output logic            err_mode
);

    localparam int ACC_W = IN_W + CAL_LOG2;

    state_t              r_state;
    state_t              w_next;
    logic [IN_W-1:0]     r_i;
    logic [IN_W-1:0]     r_q;
    logic [IN_W-1:0]     r_off_i;
    logic [IN_W-1:0]     r_off_q;
    logic [1:0]          r_mode;
    logic [ACC_W-1:0]    r_acc_i;
    logic [ACC_W-1:0]    r_acc_q;
    logic [ACC_W-1:0]    w_sum_i;
    logic [ACC_W-1:0]    w_sum_q;
    logic [CAL_LOG2-1:0] r_cal_cnt;
    logic [6:0]          r_shift;
    logic [6:0]          w_sym;
    logic [6:0]          w_frame;
    logic [2:0]          r_cnt;
    logic [2:0]          r_len;
    logic [2:0]          w_bps;
    logic [2:0]          w_len;
    logic                r_cal_pend;
    logic                r_cal_done;
    logic                r_err;
    logic                r_ready_en;
    logic [2:0]          w_gi;
    logic [2:0]          w_gq;
    logic [2:0]          w_i_left;
    logic [2:0]          w_q_left;
    logic [1:0]          w_wi;
    logic [1:0]          w_wq;
    logic                w_ready;
    logic                w_last;
    logic                w_pend;
    logic                w_take;

    qam_axis_slicer #(.IN_W(IN_W), .STEP_LOG2(STEP_LOG2)) u_slice_i (
        .sample (r_i),
        .offset (r_off_i),
        .mode   (r_mode),
        .gray   (w_gi),
        .width  (w_wi)
    );

    qam_axis_slicer #(.IN_W(IN_W), .STEP_LOG2(STEP_LOG2)) u_slice_q (
        .sample (r_q),
        .offset (r_off_q),
        .mode   (r_mode),
        .gray   (w_gq),
        .width  (w_wq)
    );

    // Left-align each axis code, then butt the Q code right after the I code.
    assign w_i_left = w_gi << (2'd3 - w_wi);
    assign w_q_left = w_gq << (2'd3 - w_wq);
    assign w_sym    = {w_i_left, 4'b0000} | ({w_q_left, 4'b0000} >> w_wi);
    assign w_bps    = bps_of(r_mode);

`ifdef QAM_DEMAP_PARITY_EN
    logic w_par;
    assign w_par   = ^w_sym;
    assign w_frame = w_sym | ((7'b1000000 >> w_bps) & {7{w_par}});
    assign w_len   = w_bps + 3'd1;
`else
    assign w_frame = w_sym;
    assign w_len   = w_bps;
`endif

    assign w_take = s_valid & r_ready_en;
    assign w_last = (r_cnt == (r_len - 3'd1));
    assign w_pend = r_cal_pend | cal_req;

    always_ff @(posedge dclk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_ready = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_ready = 1'b1;
                if (cal_req) begin
                    w_next = ST_CAL;
                end else if (w_take) begin
                    w_next = ST_DEMAP;
                end
            end
            ST_CAL: begin
                w_ready = 1'b1;
                if (w_take && (&r_cal_cnt)) begin
                    w_next = ST_IDLE;
                end
            end
            ST_DEMAP: begin
                w_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (w_last) begin
                    w_ready = ~w_pend;
                    if (w_pend) begin
                        w_next = ST_CAL;
                    end else if (w_take) begin
                        w_next = ST_DEMAP;
                    end else begin
                        w_next = ST_IDLE;
                    end
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    assign s_ready    = w_ready & r_ready_en;
    assign data_valid = (r_state == ST_SHIFT);
    assign sym_start  = data_valid & (r_cnt == 3'd0);
    assign data_out   = data_valid & r_shift[6];
    assign cal_done   = r_cal_done;
    assign err_mode   = r_err;

    assign w_sum_i = r_acc_i + {{CAL_LOG2{i_in[IN_W-1]}}, i_in};
    assign w_sum_q = r_acc_q + {{CAL_LOG2{q_in[IN_W-1]}}, q_in};

    always_ff @(posedge dclk) begin
        if (rst) begin
            r_i        <= '0;
            r_q        <= '0;
            r_mode     <= MODE_QPSK;
            r_off_i    <= '0;
            r_off_q    <= '0;
            r_acc_i    <= '0;
            r_acc_q    <= '0;
            r_cal_cnt  <= '0;
            r_shift    <= '0;
            r_cnt      <= '0;
            r_len      <= 3'd2;
            r_cal_pend <= 1'b0;
            r_cal_done <= 1'b0;
            r_err      <= 1'b0;
            r_ready_en <= 1'b0;
        end else begin
            r_ready_en <= 1'b1;
            r_cal_done <= 1'b0;

            // DEMAP is only ever entered through a symbol handshake.
            if (w_next == ST_DEMAP) begin
                r_i    <= i_in;
                r_q    <= q_in;
                r_mode <= mode;
                if (mode == MODE_RSVD) begin
                    r_err <= 1'b1;
                end
            end

            if (r_state == ST_DEMAP) begin
                r_shift <= w_frame;
                r_len   <= w_len;
                r_cnt   <= 3'd0;
            end else if (r_state == ST_SHIFT) begin
                r_shift <= {r_shift[5:0], 1'b0};
                r_cnt   <= r_cnt + 3'd1;
            end

            if (w_next == ST_CAL) begin
                r_cal_pend <= 1'b0;
            end else if (cal_req && ((r_state == ST_DEMAP) || (r_state == ST_SHIFT))) begin
                r_cal_pend <= 1'b1;
            end

            if ((r_state == ST_CAL) && w_take) begin
                if (&r_cal_cnt) begin
                    r_off_i    <= w_sum_i[ACC_W-1:CAL_LOG2];
                    r_off_q    <= w_sum_q[ACC_W-1:CAL_LOG2];
                    r_acc_i    <= '0;
                    r_acc_q    <= '0;
                    r_cal_cnt  <= '0;
                    r_cal_done <= 1'b1;
                end else begin
                    r_acc_i   <= w_sum_i;
                    r_acc_q   <= w_sum_q;
                    r_cal_cnt <= r_cal_cnt + CAL_LOG2'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/qam_demapper_serial.md
Name: qam_demapper_serial

Overview:
- Parametrised, multi-mode hard-decision QAM demapper: QPSK, 16QAM or 64QAM, selected per symbol.
- Accepts signed I/Q samples over a valid/ready handshake and removes a calibrated DC offset.
- Slices each axis to a Gray-coded index and serialises the symbol bits MSB-first on data_out.
- Sits between the front-end sample source and the serial data sink; it is the single-clock successor of the fixed 16QAM demapper.

Parameters:
- IN_W, 8, I/Q sample width (signed two's complement).
- STEP_LOG2, 4, log2 of the 64QAM decision spacing. 16QAM uses STEP_LOG2+1; QPSK slices on sign only.
- CAL_LOG2, 2, log2 of the number of samples averaged per calibration.

Ports:
- dclk  in  1  sole clock, all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- s_valid  in  1  sample valid.
- s_ready  out  1  block accepts a sample this cycle.
- i_in  in  IN_W  signed I sample.
- q_in  in  IN_W  signed Q sample.
- mode  in  2  sampled with the symbol: 00 QPSK, 01 16QAM, 10 64QAM, 11 reserved.
- cal_req  in  1  request offset calibration (level-sampled).
- cal_done  out  1  one-cycle pulse when new offsets are latched.
- data_out  out  1  serial demapped bit.
- data_valid  out  1  data_out is valid this cycle.
- sym_start  out  1  high with the first bit of each symbol.
- err_mode  out  1  sticky flag: reserved mode was seen; cleared only by rst.

Behaviour:
- Interface: one clock, dclk. Reset rst is synchronous and active-high.
- Reset values: s_ready=0 on the reset cycle, then 1 (IDLE). cal_done, data_out, data_valid, sym_start, err_mode all 0. offI=offQ=0, accumulators 0.
- FSM states: IDLE, CAL, DEMAP, SHIFT.
- IDLE:
  - s_ready=1.
  - cal_req has priority over s_valid: cal_req=1 -> CAL.
  - Otherwise a handshake (s_valid & s_ready) -> DEMAP.
- DEMAP (one cycle):
  - Compute x = sample - off in IN_W+1 bits, then saturate to [-2^(IN_W-1), 2^(IN_W-1)-1].
  - Per axis, with L levels and step S: k = (x >>> log2 S) + L/2, clamped to [0, L-1]. Gray code g = k ^ (k>>1).
  - Mode settings: QPSK L=2, 16QAM L=4 S=2^(STEP_LOG2+1), 64QAM L=8 S=2^STEP_LOG2. For QPSK, k = (x>=0).
  - Load the shift register with {gI, gQ}, each log2(L) bits, MSB first. Go to SHIFT.
- SHIFT:
  - One bit per cycle; data_valid=1; sym_start=1 on bit 0.
  - bps = 2, 4 or 6 cycles, then IDLE.
  - On the last bit: s_ready=1 unless a calibration is pending. A handshake on that cycle -> DEMAP, so there is one bubble cycle between symbols.
- Latency: handshake at edge t -> first bit on data_out at edge t+2.
- cal_req outside IDLE: latched as pending; s_ready is held 0 until CAL is entered after the current symbol.
- CAL:
  - s_ready=1. Accepted samples are summed in IN_W+CAL_LOG2-bit signed accumulators; no serial output.
  - After 2^CAL_LOG2 samples: off = sum >>> CAL_LOG2, clear the accumulators, pulse cal_done, go to IDLE.
  - Samples arriving during CAL are never demapped.
- Mode 11: demapped as QPSK; sets err_mode.
- mode is captured only at handshake; mode changes mid-symbol have no effect.
- rst mid-symbol or mid-CAL: the next edge returns to IDLE with reset values. The partial symbol and the calibration are discarded, and offsets return to 0.
- s_valid while s_ready=0 is ignored; the source holds the sample.

Optional Feature:
- QAM_DEMAP_PARITY_EN defined: each symbol frame is bps+1 bits. The final bit is the even parity (XOR) of the bps symbol bits. data_valid=1 on the parity bit; s_ready on the last-bit cycle moves to the parity cycle.
- Undefined: frame is exactly bps bits; no parity logic is present.

Decomposition:
- Package qam_demap_pkg holds:
  - mode encoding constants: MODE_QPSK, MODE_16, MODE_64, MODE_RSVD;
  - FSM state typedef;
  - bps-per-mode function;
  - Gray-encode function.
- Sub-module qam_axis_slicer, one per axis (two instances): combinational offset subtract, saturate, scale, clamp and Gray encode. Inputs: sample, offset, mode. Output: a 3-bit Gray code plus width.

Test Plan (IN_W=8, STEP_LOG2=4, CAL_LOG2=2):
- QPSK: I=+20, Q=-20, handshake at t -> data_out 1,0 at t+2,t+3; sym_start at t+2; s_ready=1 at t+3.
- 16QAM: I=70, Q=-10 -> kI=3 (clamped), gI=2; kQ=1, gQ=1 -> bits 1,0,0,1.
- 64QAM: I=-128, Q=127 -> gI=000, gQ=100 -> bits 0,0,0,1,0,0.
- Calibration: cal_req, then four samples I=10, Q=-6 -> cal_done pulse, off=(10,-6).
  - QPSK I=5, Q=0 -> corrected (-5, 6) -> bits 0,1.
  - Then I=-128 saturates to -128 (not wrapped): 64QAM gI=000.
- Back-to-back 16QAM with s_valid held: exactly one bubble cycle between frames. mode=11 -> QPSK bits and err_mode=1 and remains 1.
- rst asserted on bit 2 of a 64QAM frame -> data_valid=0 and offsets 0 at the next edge; s_ready=1 one cycle later. With QAM_DEMAP_PARITY_EN, bits 1,0,0,1 are followed by parity bit 0.
